note_feeder: RTL and testbench
==============================

NOTE_FEEDER -- requirements
Module: note_feeder

Interface
REQ-001 Parameter DEPTH, default 8: number of note history slots; a power of two, 2..16.
REQ-002 Parameter ORIGIN_X, default 11'd600: left pixel column of the history list.
REQ-003 Parameter ORIGIN_Y, default 10'd40: top pixel row of slot 0.
REQ-004 Parameter ROW_SHIFT, default 4: log2 of the row pitch in pixels (default pitch 16).
REQ-005 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 new_note  input  1  one-cycle strobe; note_in is valid in that cycle.
REQ-009 note_in  input  NOTE_WIDTH(6)  note code from the player.
REQ-010 clear  input  1  one-cycle strobe that empties the history.
REQ-011 frame_start  input  1  one-cycle strobe at the start of each video frame.
REQ-012 x  input  11  current pixel column; y  input  10  current pixel row.
REQ-013 x1  output  11  slot box left edge; y1  output  10  slot box top edge.
REQ-014 note_out  output  6  note code for the slot under (x,y).
REQ-015 valid  output  1  (x,y) is inside an occupied displayed slot.
REQ-016 count  output  5  live number of stored notes; overflow  output  1  sticky, set when a note was overwritten.

Function
REQ-017 The live buffer SHALL be a DEPTH-entry circular buffer with wr_ptr and count; new_note writes note_in at wr_ptr, wr_ptr increments mod DEPTH, count saturates at DEPTH.
REQ-018 A new_note with count==DEPTH SHALL overwrite the oldest entry and set overflow.
REQ-019 clear SHALL set count=0, wr_ptr=0 and overflow=0 next cycle; clear together with new_note: clear wins and the note is dropped.
REQ-020 On frame_start the block SHALL copy the live buffer to a shadow array reordered newest-first (shadow[0] = newest) and latch shadow_count=count.
REQ-021 frame_start coincident with new_note: the shadow SHALL include the new note; coincident with clear: shadow_count=0.
REQ-022 Shadow contents SHALL change only on frame_start or reset; there is no tearing within a frame.
REQ-023 Slot index s = (y - ORIGIN_Y) >> ROW_SHIFT, computed at 10-bit width and only when y >= ORIGIN_Y.
REQ-024 valid=1 iff y >= ORIGIN_Y, s < shadow_count, and ORIGIN_X <= x < ORIGIN_X+32.
REQ-025 When valid: x1=ORIGIN_X, y1=ORIGIN_Y + (s << ROW_SHIFT), note_out=shadow[s]; otherwise x1, y1 and note_out are 0.
REQ-026 Pixel outputs SHALL be combinational from x, y and registered shadow state, with zero added latency relative to x/y.

Reset
REQ-027 Reset SHALL clear live buffer, shadow, wr_ptr, count, shadow_count and overflow to 0, giving valid=0, x1=0, y1=0 and note_out=0.
REQ-028 Reset mid-frame SHALL blank the display immediately; the first frame_start after reset latches an empty shadow unless a note arrived.

Configuration
REQ-029 With NOTE_FEEDER_DEDUP_EN defined, a new_note whose note_in equals the newest stored note (count>0) SHALL be ignored.
REQ-030 Without NOTE_FEEDER_DEDUP_EN, every new_note SHALL be stored.

Structure
REQ-031 NOTE_WIDTH, the default DEPTH and the 32-pixel slot width SHALL live in the shared music-display package/defines.
REQ-032 Pixel-to-slot decoding (REQ-023..025) SHALL be a sub-module note_slot_decode; the buffer, shadow and FSM-free control stay in note_feeder.

Verification
REQ-033 reset; new_note 0x05,0x07; frame_start; pixel (600,40) -> valid=1, note_out=0x07, y1=40; pixel (610,56) -> note_out=0x05, y1=56.
REQ-034 10 notes 1..10 with DEPTH=8 -> count=8, overflow=1; after frame_start, slot 0=10 and slot 7=3.
REQ-035 new_note 0x09 without frame_start -> pixel (600,40) still shows the previous shadow; after frame_start -> note_out=0x09.
REQ-036 clear and new_note in the same cycle -> count=0 and overflow=0; after frame_start, valid=0 everywhere.
REQ-037 Pixel (632,40), (599,40) and (600,39) -> valid=0 and x1=y1=note_out=0.
REQ-038 With NOTE_FEEDER_DEDUP_EN defined, new_note 0x04 twice -> count=1; without the macro -> count=2.

Source files
------------

// File: rtl/note_feeder_pkg.sv
// Shared music-display definitions for the note history feeder.
// The optional duplicate filter is enabled with NOTE_FEEDER_DEDUP_EN.
package note_feeder_pkg;

    localparam int NOTE_WIDTH    = 6;
    localparam int DEFAULT_DEPTH = 8;
    localparam int SLOT_WIDTH    = 32;
    localparam int COUNT_WIDTH   = 5;

    typedef logic [NOTE_WIDTH-1:0] note_t;

    // True when column v lies in [lo, lo + SLOT_WIDTH), evaluated at 12 bits so the top edge cannot wrap.
    function automatic logic in_slot_span(input logic [10:0] v, input logic [10:0] lo);
        logic [11:0] hi;
        hi = {1'b0, lo} + 12'(SLOT_WIDTH);
        return ({1'b0, v} >= {1'b0, lo}) && ({1'b0, v} < hi);
    endfunction

endpackage

// File: rtl/note_slot_decode.sv
// Maps the current pixel (x,y) onto a history slot box and looks up its note.
// Purely combinational so the pixel outputs track x/y with no latency.
module note_slot_decode
    import note_feeder_pkg::*;
#(
    parameter int          DEPTH     = DEFAULT_DEPTH,
    parameter logic [10:0] ORIGIN_X  = 11'd600,
    parameter logic [9:0]  ORIGIN_Y  = 10'd40,
    parameter int          ROW_SHIFT = 4
) (
    input  logic [10:0]                 x,
    input  logic [9:0]                  y,
    input  logic [4:0]                  shadow_count,
    input  logic [DEPTH*NOTE_WIDTH-1:0] shadow_flat,
    output logic [10:0]                 x1,
    output logic [9:0]                  y1,
    output logic [5:0]                  note_out,
    output logic                        valid
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [9:0]       y_off_s;
    logic [9:0]       slot_s;
    logic [PTR_W-1:0] slot_idx_s;
    logic             in_y_s;
    logic             in_x_s;
    logic             in_slot_s;
    logic             valid_s;

    assign y_off_s    = y - ORIGIN_Y;
    assign slot_s     = y_off_s >> ROW_SHIFT;
    assign slot_idx_s = slot_s[PTR_W-1:0];
    assign in_y_s     = (y >= ORIGIN_Y);
    assign in_x_s     = in_slot_span(x, ORIGIN_X);
    // slot_s < shadow_count <= DEPTH guarantees slot_idx_s is an exact index when valid.
    assign in_slot_s  = (slot_s < {5'd0, shadow_count});
    assign valid_s    = in_y_s && in_x_s && in_slot_s;
    assign valid      = valid_s;

    // Box geometry and note lookup, forced to zero outside an occupied slot.
    always_comb begin
        if (valid_s) begin
            x1       = ORIGIN_X;
            y1       = ORIGIN_Y + (slot_s << ROW_SHIFT);
            note_out = shadow_flat[slot_idx_s*NOTE_WIDTH +: NOTE_WIDTH];
        end else begin
            x1       = 11'd0;
            y1       = 10'd0;
            note_out = 6'd0;
        end
    end

endmodule

// File: rtl/note_feeder.sv
// Note history buffer with a per-frame newest-first shadow copy for display.
// Define NOTE_FEEDER_DEDUP_EN to drop a note equal to the newest stored one.
module note_feeder
    import note_feeder_pkg::*;
#(
    parameter int          DEPTH     = DEFAULT_DEPTH,
    parameter logic [10:0] ORIGIN_X  = 11'd600,
    parameter logic [9:0]  ORIGIN_Y  = 10'd40,
    parameter int          ROW_SHIFT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_note,
    input  logic [5:0]  note_in,
    input  logic        clear,
    input  logic        frame_start,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    output logic [10:0] x1,
    output logic [9:0]  y1,
    output logic [5:0]  note_out,
    output logic        valid,
    output logic [4:0]  count,
    output logic        overflow
);

    localparam int                     PTR_W   = $clog2(DEPTH);
    localparam logic [COUNT_WIDTH-1:0] DEPTH_C = COUNT_WIDTH'(DEPTH);

    note_t                       mem_r [DEPTH];
    note_t                       mem_nx_s [DEPTH];
    logic [PTR_W-1:0]            wr_ptr_r, wr_ptr_nx_s;
    logic [COUNT_WIDTH-1:0]      count_r, count_nx_s;
    logic                        overflow_r, overflow_nx_s;
    logic [DEPTH*NOTE_WIDTH-1:0] shadow_r, shadow_nx_s;
    logic [COUNT_WIDTH-1:0]      shadow_count_r;
    logic                        dup_s;
    logic                        accept_s;

`ifdef NOTE_FEEDER_DEDUP_EN
    assign dup_s = (count_r != 5'd0) && (note_in == mem_r[wr_ptr_r - PTR_W'(1)]);
`else
    assign dup_s = 1'b0;
`endif

    assign accept_s = new_note && !dup_s;

    // Next live-buffer state; the shadow snapshot reuses it so a coincident note or clear is seen.
    always_comb begin
        mem_nx_s      = mem_r;
        wr_ptr_nx_s   = wr_ptr_r;
        count_nx_s    = count_r;
        overflow_nx_s = overflow_r;
        if (clear) begin
            wr_ptr_nx_s   = {PTR_W{1'b0}};
            count_nx_s    = 5'd0;
            overflow_nx_s = 1'b0;
        end else if (accept_s) begin
            mem_nx_s[wr_ptr_r] = note_in;
            wr_ptr_nx_s        = wr_ptr_r + PTR_W'(1);
            if (count_r == DEPTH_C) begin
                overflow_nx_s = 1'b1;
            end else begin
                count_nx_s = count_r + 5'd1;
            end
        end else begin
            wr_ptr_nx_s = wr_ptr_r;
        end
    end

    // Newest-first reordering: slot i holds the entry written i+1 places before the write pointer.
    always_comb begin
        shadow_nx_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            shadow_nx_s[i*NOTE_WIDTH +: NOTE_WIDTH] = mem_nx_s[PTR_W'(wr_ptr_nx_s - PTR_W'(i + 1))];
        end
    end

    // Live buffer and shadow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 6'd0;
            end
            wr_ptr_r       <= {PTR_W{1'b0}};
            count_r        <= 5'd0;
            overflow_r     <= 1'b0;
            shadow_r       <= '0;
            shadow_count_r <= 5'd0;
        end else begin
            mem_r      <= mem_nx_s;
            wr_ptr_r   <= wr_ptr_nx_s;
            count_r    <= count_nx_s;
            overflow_r <= overflow_nx_s;
            if (frame_start) begin
                shadow_r       <= shadow_nx_s;
                shadow_count_r <= count_nx_s;
            end else begin
                shadow_r       <= shadow_r;
                shadow_count_r <= shadow_count_r;
            end
        end
    end

    assign count    = count_r;
    assign overflow = overflow_r;

    note_slot_decode #(
        .DEPTH     (DEPTH),
        .ORIGIN_X  (ORIGIN_X),
        .ORIGIN_Y  (ORIGIN_Y),
        .ROW_SHIFT (ROW_SHIFT)
    ) u_decode (
        .x            (x),
        .y            (y),
        .shadow_count (shadow_count_r),
        .shadow_flat  (shadow_r),
        .x1           (x1),
        .y1           (y1),
        .note_out     (note_out),
        .valid        (valid)
    );

endmodule

// File: tb/tb_note_feeder.sv
// Self-checking bench for note_feeder: a queue-based history model predicts pixel outputs.
// Honours NOTE_FEEDER_DEDUP_EN when the design is built with it.
module tb_note_feeder;

    logic        clk = 1'b0;
    logic        reset, new_note, clear, frame_start;
    logic [5:0]  note_in;
    logic [10:0] x;
    logic [9:0]  y;
    logic [10:0] x1;
    logic [9:0]  y1;
    logic [5:0]  note_out;
    logic        valid;
    logic [4:0]  count;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [10:0] px;
        logic [9:0]  py;
        logic        v;
        logic [10:0] x1;
        logic [9:0]  y1;
        logic [5:0]  n;
    } pix_t;

    pix_t       sb_q [$];
    logic [5:0] live_q [$];
    logic [5:0] shadow_m [8];
    int         scnt_m;
    logic       ovf_m;

    always #5 clk = ~clk;

    note_feeder dut (
        .clk(clk), .reset(reset), .new_note(new_note), .note_in(note_in),
        .clear(clear), .frame_start(frame_start), .x(x), .y(y),
        .x1(x1), .y1(y1), .note_out(note_out), .valid(valid),
        .count(count), .overflow(overflow)
    );

    function automatic pix_t expect_pix(input int px, input int py);
        pix_t e;
        int   s;
        e.px = 11'(px); e.py = 10'(py);
        e.v = 1'b0; e.x1 = 11'd0; e.y1 = 10'd0; e.n = 6'd0;
        if (py >= 40 && px >= 600 && px < 632) begin
            s = (py - 40) / 16;
            if (s < scnt_m) begin
                e.v = 1'b1; e.x1 = 11'd600; e.y1 = 10'(40 + s * 16); e.n = shadow_m[s];
            end
        end
        return e;
    endfunction

    task automatic model_note(input logic [5:0] n);
        bit skip = 1'b0;
`ifdef NOTE_FEEDER_DEDUP_EN
        if (live_q.size() > 0 && live_q[live_q.size()-1] == n) skip = 1'b1;
`endif
        if (!skip) begin
            live_q.push_back(n);
            if (live_q.size() > 8) begin
                void'(live_q.pop_front());
                ovf_m = 1'b1;
            end
        end
    endtask

    task automatic model_frame();
        scnt_m = live_q.size();
        for (int i = 0; i < scnt_m; i++) shadow_m[i] = live_q[scnt_m - 1 - i];
    endtask

    task automatic model_clear();
        live_q.delete();
        ovf_m = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_note(input logic [5:0] n);
        new_note = 1'b1; note_in = n; model_note(n);
        cyc();
        new_note = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1; model_frame();
        cyc();
        frame_start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1; model_clear();
        cyc();
        clear = 1'b0;
    endtask

    task automatic probe(input int px, input int py);
        x = 11'(px); y = 10'(py);
        sb_q.push_back(expect_pix(px, py));
        @(negedge clk);
        #1;
    endtask

    // Scoreboard: each probe is compared against its predicted pixel outputs at the falling edge.
    initial begin
        pix_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if ({valid, x1, y1, note_out} !== {e.v, e.x1, e.y1, e.n}) begin
                    n_bad++;
                    $display("FAIL pix(%0d,%0d): got v=%0b x1=%0d y1=%0d n=%0h, want v=%0b x1=%0d y1=%0d n=%0h",
                             e.px, e.py, valid, x1, y1, note_out, e.v, e.x1, e.y1, e.n);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        model_clear(); scnt_m = 0;
        cyc(); cyc();
        reset = 1'b0;
        n_cmp++;
        if ({count, overflow} !== {5'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_status: count=%0d ovf=%0b, want 0/0", count, overflow);
        end
        probe(600, 40);
    endtask

    task automatic test_basic();
        send_note(6'h05); send_note(6'h07); frame();
        probe(600, 40);
        n_cmp++;
        if ({valid, note_out, y1} !== {1'b1, 6'h07, 10'd40}) begin
            n_bad++;
            $display("FAIL basic_slot0: v=%0b n=%0h y1=%0d, want 1/07/40", valid, note_out, y1);
        end
        probe(610, 56);
        n_cmp++;
        if ({note_out, y1} !== {6'h05, 10'd56}) begin
            n_bad++;
            $display("FAIL basic_slot1: n=%0h y1=%0d, want 05/56", note_out, y1);
        end
        probe(615, 72);
    endtask

    task automatic test_overflow();
        do_clear();
        for (int i = 1; i <= 10; i++) send_note(6'(i));
        n_cmp++;
        if ({count, overflow} !== {5'd8, 1'b1}) begin
            n_bad++;
            $display("FAIL ovf_status: count=%0d ovf=%0b, want 8/1", count, overflow);
        end
        frame();
        probe(600, 40);
        n_cmp++;
        if (note_out !== 6'd10) begin
            n_bad++;
            $display("FAIL ovf_slot0: n=%0d, want 10", note_out);
        end
        probe(631, 152 + 15);
        n_cmp++;
        if (note_out !== 6'd3) begin
            n_bad++;
            $display("FAIL ovf_slot7: n=%0d, want 3", note_out);
        end
        probe(600, 168);
    endtask

    task automatic test_no_tear();
        send_note(6'h09);
        probe(600, 40);
        n_cmp++;
        if (note_out !== 6'd10) begin
            n_bad++;
            $display("FAIL no_tear_hold: n=%0h, want 0a", note_out);
        end
        frame();
        probe(600, 40);
        n_cmp++;
        if (note_out !== 6'h09) begin
            n_bad++;
            $display("FAIL no_tear_update: n=%0h, want 09", note_out);
        end
        n_cmp++;
        if (overflow !== ovf_m) begin
            n_bad++;
            $display("FAIL ovf_sticky: ovf=%0b, want %0b", overflow, ovf_m);
        end
    endtask

    task automatic test_clear_collide();
        clear = 1'b1; new_note = 1'b1; note_in = 6'h2a; model_clear();
        cyc();
        clear = 1'b0; new_note = 1'b0;
        n_cmp++;
        if ({count, overflow} !== {5'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL clear_collide: count=%0d ovf=%0b, want 0/0", count, overflow);
        end
        frame();
        for (int r = 0; r < 8; r++) probe(600 + 4 * r, 40 + 16 * r);
    endtask

    task automatic test_bounds();
        send_note(6'h11); frame();
        probe(632, 40);
        n_cmp++;
        if ({valid, x1, y1, note_out} !== 28'd0) begin
            n_bad++;
            $display("FAIL bound_right: v=%0b x1=%0d y1=%0d n=%0h, want all 0", valid, x1, y1, note_out);
        end
        probe(599, 40);
        probe(600, 39);
        n_cmp++;
        if ({valid, x1, y1, note_out} !== 28'd0) begin
            n_bad++;
            $display("FAIL bound_top: v=%0b x1=%0d y1=%0d n=%0h, want all 0", valid, x1, y1, note_out);
        end
        probe(631, 55);
        probe(600, 56);
    endtask

    task automatic test_frame_coincident();
        frame_start = 1'b1; new_note = 1'b1; note_in = 6'h33;
        model_note(6'h33); model_frame();
        cyc();
        frame_start = 1'b0; new_note = 1'b0;
        probe(600, 40);
        n_cmp++;
        if (note_out !== 6'h33) begin
            n_bad++;
            $display("FAIL frame_with_note: n=%0h, want 33", note_out);
        end
        probe(600, 56);
        frame_start = 1'b1; clear = 1'b1; model_clear(); model_frame();
        cyc();
        frame_start = 1'b0; clear = 1'b0;
        probe(600, 40);
        n_cmp++;
        if (valid !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_with_clear: v=%0b, want 0", valid);
        end
    endtask

    task automatic test_dedup();
        int exp_cnt;
        do_clear();
        send_note(6'h04); send_note(6'h04);
`ifdef NOTE_FEEDER_DEDUP_EN
        exp_cnt = 1;
`else
        exp_cnt = 2;
`endif
        n_cmp++;
        if (count !== 5'(exp_cnt)) begin
            n_bad++;
            $display("FAIL dedup_count: count=%0d, want %0d", count, exp_cnt);
        end
        frame();
        probe(600, 40); probe(600, 56);
    endtask

    task automatic test_back_to_back_random();
        do_clear();
        for (int i = 0; i < 13; i++) send_note(6'($urandom_range(0, 63)));
        frame();
        for (int i = 0; i < 20; i++) probe($urandom_range(590, 640), $urandom_range(30, 180));
        for (int i = 0; i < 8; i++) probe(600, 40 + 16 * i);
    endtask

    task automatic test_reset_midframe();
        reset = 1'b1; model_clear(); scnt_m = 0;
        cyc();
        reset = 1'b0;
        probe(600, 40);
        frame();
        probe(600, 40);
        send_note(6'h21); frame();
        probe(600, 40);
    endtask

    initial begin
        reset = 1'b0; new_note = 1'b0; clear = 1'b0; frame_start = 1'b0;
        note_in = 6'd0; x = 11'd0; y = 10'd0;
        scnt_m = 0; ovf_m = 1'b0;
        for (int i = 0; i < 8; i++) shadow_m[i] = 6'd0;
        test_reset();
        test_basic();
        test_overflow();
        test_no_tear();
        test_clear_collide();
        test_bounds();
        test_frame_coincident();
        test_dedup();
        test_back_to_back_random();
        test_reset_midframe();
        cyc();
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
